// File: rtl/grom_io_pkg.sv
// Shared definitions for the GROM IO peripherals: UART transmitter state
// encoding, default bit period and status-register bit positions.
package grom_io_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_e;

    localparam int unsigned UART_CLK_DIV_DEFAULT = 4;

    localparam int unsigned STAT_BUSY_BIT = 0;
    localparam int unsigned STAT_FULL_BIT = 1;
    localparam int unsigned STAT_OVF_BIT  = 2;

endpackage

// File: rtl/grom_uart_tx_if.sv
// CPU IO-bus bundle for the UART transmitter: address, write data/strobe,
// IO-space qualifier and combinational read data.
interface grom_uart_tx_if;

    logic [11:0] addr;
    logic [7:0]  data_in;
    logic        we;
    logic        ioreq;
    logic [7:0]  data_out;

    modport master (
        output addr,
        output data_in,
        output we,
        output ioreq,
        input  data_out
    );

    modport slave (
        input  addr,
        input  data_in,
        input  we,
        input  ioreq,
        output data_out
    );

endinterface

// File: rtl/grom_uart_fifo.sv
// Transmit queue for grom_uart_tx. Define UART_TX_FIFO_EN for a 4-entry
// circular queue; otherwise a single holding register (depth 1) is built.
module grom_uart_fifo
    import grom_io_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

`ifdef UART_TX_FIFO_EN

    logic [7:0] mem_q [4];
    logic [7:0] mem_d [4];
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0] count_q, count_d;
    logic       do_push, do_pop;

    assign full  = (count_q == 3'd4);
    assign empty = (count_q == 3'd0);
    assign dout  = mem_q[rd_ptr_q];

    // When full, a same-edge pop frees the slot the push is about to overwrite.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 4; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`else

    logic [7:0] hold_q, hold_d;
    logic       valid_q, valid_d;
    logic       do_push, do_pop;

    assign full  = valid_q;
    assign empty = !valid_q;
    assign dout  = hold_q;

    always_comb begin
        hold_d  = hold_q;
        valid_d = valid_q;
        do_pop  = pop && valid_q;
        do_push = push && (!valid_q || do_pop);
        if (do_pop) begin
            valid_d = 1'b0;
        end
        if (do_push) begin
            hold_d  = din;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            valid_q <= valid_d;
        end
    end

`endif

endmodule

// File: rtl/grom_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: data port at BASE_PORT, status port at
// BASE_PORT+1. Queue depth selected by UART_TX_FIFO_EN (see grom_uart_fifo).
module grom_uart_tx
    import grom_io_pkg::*;
#(
    parameter int unsigned CLK_DIV   = UART_CLK_DIV_DEFAULT,
    parameter logic [11:0] BASE_PORT = 12'h000
) (
    input  logic           clk,
    input  logic           reset,
    grom_uart_tx_if.slave  bus,
    output logic           tx,
    output logic           busy
);

    localparam logic [11:0] STAT_PORT = BASE_PORT + 12'd1;
    localparam logic [7:0]  BAUD_MAX  = 8'(CLK_DIV - 1);

    uart_tx_state_e state_q, state_d;
    logic [7:0]     baud_q, baud_d;
    logic [3:0]     bit_idx_q, bit_idx_d;
    logic [7:0]     shift_q, shift_d;
    logic           tx_q, tx_d;
    logic           ovf_q, ovf_d;

    logic           push_req, clr_req, rd_stat;
    logic           pop;
    logic [7:0]     fifo_dout;
    logic           fifo_full, fifo_empty;
    logic [7:0]     status;

    assign push_req = bus.ioreq && bus.we && (bus.addr == BASE_PORT) && !reset;
    assign clr_req  = bus.ioreq && bus.we && (bus.addr == STAT_PORT);
    assign rd_stat  = bus.ioreq && !bus.we && (bus.addr == STAT_PORT);

    grom_uart_fifo u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (pop),
        .din   (bus.data_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign tx = tx_q;

    always_comb begin
        busy = (state_q != IDLE) || !fifo_empty;
    end

    always_comb begin
        status                = '0;
        status[STAT_BUSY_BIT] = busy;
        status[STAT_FULL_BIT] = fifo_full;
        status[STAT_OVF_BIT]  = ovf_q;
        bus.data_out          = rd_stat ? status : '0;
    end

    // A push into a full queue only overflows if the FSM is not popping this edge.
    always_comb begin
        ovf_d = ovf_q;
        if (push_req && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end
        if (clr_req) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        if (state_q == IDLE) begin
            tx_d      = 1'b1;
            baud_d    = '0;
            bit_idx_d = '0;
            if (!fifo_empty) begin
                pop     = 1'b1;
                shift_d = fifo_dout;
                state_d = START;
                tx_d    = 1'b0;
            end
        end else if (baud_q == BAUD_MAX) begin
            baud_d = '0;
            case (state_q)
                START: begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end
                DATA: begin
                    if (bit_idx_q == 4'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end
                STOP: begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_dout;
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end
            endcase
        end else begin
            baud_d = baud_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_grom_uart_tx.sv
// Bench for grom_uart_tx: frame-level reference model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_grom_uart_tx;

    localparam int unsigned DIV = 4;
`ifdef UART_TX_FIFO_EN
    localparam int unsigned DEPTH = 4;
    localparam int unsigned NB    = 6;
    localparam int unsigned NFR   = 5;
`else
    localparam int unsigned DEPTH = 1;
    localparam int unsigned NB    = 3;
    localparam int unsigned NFR   = 2;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tx, busy;

    grom_uart_tx_if bus ();

    grom_uart_tx #(
        .CLK_DIV   (DIV),
        .BASE_PORT (12'h000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .tx    (tx),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // Reference model: byte queue plus the frame currently on the line.
    logic [7:0] mq[$];
    bit         m_ovf = 1'b0;
    bit         m_active = 1'b0;
    int         m_el = 0;
    logic [7:0] m_byte = 8'h00;
    bit         model_on = 1'b0;

    function automatic logic m_tx();
        int k;
        if (!m_active) return 1'b1;
        k = m_el / DIV;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_byte[k-1];
        return 1'b1;
    endfunction

    function automatic logic [7:0] m_status();
        logic [7:0] s;
        s = 8'h00;
        if (bus.ioreq && !bus.we && bus.addr == 12'h001) begin
            s[0] = m_active || (mq.size() > 0);
            s[1] = (mq.size() == DEPTH);
            s[2] = m_ovf;
        end
        return s;
    endfunction

    task automatic model_step();
        if (reset) begin
            mq.delete();
            m_ovf    = 1'b0;
            m_active = 1'b0;
            m_el     = 0;
            model_on = 1'b1;
        end else if (model_on) begin
            if (m_active) begin
                m_el++;
                if (m_el == 10 * DIV) begin
                    if (mq.size() > 0) begin
                        m_byte = mq.pop_front();
                        m_el   = 0;
                    end else begin
                        m_active = 1'b0;
                    end
                end
            end else if (mq.size() > 0) begin
                m_byte   = mq.pop_front();
                m_el     = 0;
                m_active = 1'b1;
            end
            if (bus.ioreq && bus.we && bus.addr == 12'h000) begin
                if (mq.size() < DEPTH) mq.push_back(bus.data_in);
                else m_ovf = 1'b1;
            end
            if (bus.ioreq && bus.we && bus.addr == 12'h001) m_ovf = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            if (model_on) begin
                check("model_tx", {31'b0, tx}, {31'b0, m_tx()});
                check("model_busy", {31'b0, busy}, {31'b0, m_active || (mq.size() > 0)});
                check("model_data_out", {24'b0, bus.data_out}, {24'b0, m_status()});
            end
        end
    end

    task automatic drive(input logic io, input logic w, input logic [11:0] a, input logic [7:0] d);
        bus.ioreq   = io;
        bus.we      = w;
        bus.addr    = a;
        bus.data_in = d;
    endtask

    task automatic bus_idle();
        drive(1'b0, 1'b0, 12'h000, 8'h00);
    endtask

    logic frame55 [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int e;

    initial begin
        bus_idle();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_tx", {31'b0, tx}, 32'd1);
        check("reset_busy", {31'b0, busy}, 32'd0);
        drive(1'b1, 1'b0, 12'h001, 8'h00);
        #2 check("reset_status", {24'b0, bus.data_out}, 32'h00);

        // RAM write and unmapped IO write must be ignored
        @(negedge clk) drive(1'b0, 1'b1, 12'h000, 8'hAA);
        @(negedge clk) drive(1'b1, 1'b1, 12'h005, 8'hBB);
        @(negedge clk) bus_idle();
        repeat (10) begin
            @(negedge clk);
            check("ram_write_tx", {31'b0, tx}, 32'd1);
            check("ram_write_busy", {31'b0, busy}, 32'd0);
        end
        drive(1'b1, 1'b0, 12'h002, 8'h00);
        #2 check("unmapped_read", {24'b0, bus.data_out}, 32'h00);

        // Single 0x55 frame with literal waveform
        @(negedge clk) drive(1'b1, 1'b1, 12'h000, 8'h55);
        @(negedge clk) bus_idle();
        check("latency_tx", {31'b0, tx}, 32'd1);
        check("latency_busy", {31'b0, busy}, 32'd1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("frame55_tx", {31'b0, tx}, {31'b0, frame55[i/4]});
            check("frame55_busy", {31'b0, busy}, 32'd1);
        end
        @(negedge clk);
        check("frame55_end_busy", {31'b0, busy}, 32'd0);
        check("frame55_end_tx", {31'b0, tx}, 32'd1);

        // Burst overflow, ovf clear, back-to-back frames
        repeat (3) @(negedge clk);
        drive(1'b1, 1'b1, 12'h000, 8'h10);
        for (int i = 1; i < int'(NB); i++) begin
            @(negedge clk) drive(1'b1, 1'b1, 12'h000, 8'h10 + 8'(i));
        end
        @(negedge clk);
        e = NB - 1;
        drive(1'b1, 1'b0, 12'h001, 8'h00);
        #2 check("burst_status_ovf", {24'b0, bus.data_out}, 32'h07);
        @(negedge clk);
        e++;
        drive(1'b1, 1'b1, 12'h001, 8'h5A);
        @(negedge clk);
        e++;
        drive(1'b1, 1'b0, 12'h001, 8'h00);
        #2 check("status_after_clear_full", {24'b0, bus.data_out}, 32'h03);
        @(negedge clk);
        e++;
        bus_idle();
        while (e < 45) begin
            @(negedge clk);
            e++;
        end
        drive(1'b1, 1'b0, 12'h001, 8'h00);
        #2 check("status_after_clear_partial", {24'b0, bus.data_out}, 32'h01);
        @(negedge clk);
        e++;
        bus_idle();
        while (busy && e < 400) begin
            @(negedge clk);
            e++;
        end
        check("burst_busy_fall_edge", e, 1 + 40 * NFR);

        // Reset mid-DATA, with a push coinciding with reset
        repeat (3) @(negedge clk);
        drive(1'b1, 1'b1, 12'h000, 8'hC3);
        @(negedge clk) drive(1'b1, 1'b1, 12'h000, 8'h3C);
        @(negedge clk) bus_idle();
        repeat (14) @(negedge clk);
        check("pre_reset_busy", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        drive(1'b1, 1'b1, 12'h000, 8'h77);
        @(negedge clk);
        reset = 1'b0;
        check("midframe_reset_tx", {31'b0, tx}, 32'd1);
        check("midframe_reset_busy", {31'b0, busy}, 32'd0);
        drive(1'b1, 1'b0, 12'h001, 8'h00);
        #2 check("midframe_reset_status", {24'b0, bus.data_out}, 32'h00);
        @(negedge clk) bus_idle();
        repeat (60) begin
            @(negedge clk);
            check("post_reset_tx_idle", {31'b0, tx}, 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog at %0t: got timeout expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/grom_uart_tx.md
GROM_UART_TX -- requirements
Module: grom_uart_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per serial bit, legal range 2..255.
REQ-002 SHALL have parameter BASE_PORT, default 12'h000: IO address of the data port; the status port is BASE_PORT+1.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port addr  input  12  CPU address bus.
REQ-006 SHALL have port data_in  input  8  CPU write data.
REQ-007 SHALL have port we  input  1  CPU write strobe.
REQ-008 SHALL have port ioreq  input  1  high when the CPU cycle targets IO space rather than RAM.
REQ-009 SHALL have port data_out  output  8  IO read data, combinational.
REQ-010 SHALL have port tx  output  1  serial line, idle high.
REQ-011 SHALL have port busy  output  1  high while a frame is on the line or the queue is non-empty.

Function
REQ-012 SHALL push data_in into the transmit queue on a rising edge where ioreq=1, we=1 and addr=BASE_PORT, if the queue is not full.
REQ-013 SHALL drop a push to a full queue and set sticky flag ovf; a pop on the same edge frees a slot, so that push is accepted with ovf unchanged.
REQ-014 SHALL clear ovf on any write with ioreq=1, we=1 and addr=BASE_PORT+1, regardless of data_in.
REQ-015 SHALL drive data_out = {5'b0, ovf, full, busy} when ioreq=1, we=0 and addr=BASE_PORT+1; otherwise data_out SHALL be 8'h00.
REQ-016 SHALL implement FSM states IDLE, START, DATA, STOP; a 4-bit bit index counts within DATA; a baud counter counts 0..CLK_DIV-1 within each bit.
REQ-017 SHALL, in IDLE with the queue non-empty, pop the head into a shift register and enter START on the same edge.
REQ-018 SHALL drive tx=0 for CLK_DIV cycles in START, data bits LSB first for CLK_DIV cycles each in DATA, and tx=1 for CLK_DIV cycles in STOP; one frame is exactly 10*CLK_DIV cycles.
REQ-019 SHALL, at the end of STOP, pop and go directly to START if the queue is non-empty (no idle gap), else go to IDLE.
REQ-020 SHALL have latency: a write at edge N with an empty queue and IDLE state puts tx low after edge N+1 (no bypass path).
REQ-021 SHALL register tx; the output SHALL be glitch-free.
REQ-022 SHALL ignore writes and reads with ioreq=0 or a non-matching addr entirely.

Reset
REQ-023 SHALL, on a rising edge with reset=1, set state IDLE, tx=1, queue empty, ovf=0, counters 0 and busy=0, including when reset arrives mid-frame; the partial frame is abandoned.
REQ-024 SHALL ignore a push coinciding with reset.

Configuration
REQ-025 SHALL, with UART_TX_FIFO_EN defined, use a 4-entry circular queue with 2-bit read/write pointers that wrap and an occupancy count of 0..4.
REQ-026 SHALL, without UART_TX_FIFO_EN, use a single holding register with a valid bit (depth 1); all other behaviour is identical.

Structure
REQ-027 SHALL take the FSM state encoding, default CLK_DIV and the status bit positions from shared package grom_io_pkg.
REQ-028 SHALL place the queue in sub-module grom_uart_fifo, which has push/pop/full/empty ports; the FSM and baud logic stay in grom_uart_tx.

Verification
REQ-029 SHALL cover: with CLK_DIV=4, write 0x55 to port 0 -> tx after the write edge is 0 (4 cycles), then 1,0,1,0,1,0,1,0 (4 cycles each), then 1 (4 cycles); busy falls 40 cycles after the frame starts.
REQ-030 SHALL cover: with the FIFO enabled, write 6 bytes on consecutive cycles -> the first is popped, 4 are queued, the 6th is dropped, status read = 8'h07, and 5 frames are sent back-to-back (200 cycles, no gap).
REQ-031 SHALL cover: after REQ-030, write any value to port 1 -> ovf=0; a status read during transmission returns 8'h03 or 8'h01 according to fill level.
REQ-032 SHALL cover: assert reset for 1 cycle at mid-DATA -> tx=1 and status=8'h00 on the next cycle, and no further frames are sent.
REQ-033 SHALL cover: with ioreq=0, we=1 and addr=0 (a RAM write) -> no push, and tx stays 1.
REQ-034 SHALL cover: without UART_TX_FIFO_EN, write 3 bytes back-to-back -> byte 1 is sent, byte 2 is held, byte 3 is dropped, ovf=1.
